vga_timing_ctrl: RTL and testbench



---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_timing_ctrl_if.sv | 23 ++
 rtl/vga_timing_counter.sv | 56 +++++
 rtl/vga_timing_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants, register map and types for the VGA timing/colour generator.
package vga_pkg;

  localparam int unsigned H_DISP = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BP   = 48;
  localparam int unsigned V_DISP = 480;
  localparam int unsigned V_FP   = 10;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 33;

  localparam int unsigned CntW   = 12;
  localparam int unsigned CoordW = 11;

  typedef enum logic [2:0] {
    REG_CTRL      = 3'd0,
    REG_BG        = 3'd1,
    REG_FG        = 3'd2,
    REG_BOX_START = 3'd3,
    REG_BOX_END   = 3'd4,
    REG_STATUS    = 3'd5,
    REG_FRAME_CNT = 3'd6,
    REG_RSVD      = 3'd7
  } reg_idx_e;

  typedef struct packed {
    logic [CoordW-1:0] x0;
    logic [CoordW-1:0] y0;
    logic [CoordW-1:0] x1;
    logic [CoordW-1:0] y1;
  } box_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Device-bus port bundle between the CPU side and the VGA controller.
interface vga_timing_ctrl_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic                 device_req_i;
  logic [AddrWidth-1:0] device_addr_i;
  logic                 device_we_i;
  logic [3:0]           device_be_i;
  logic [DataWidth-1:0] device_wdata_i;
  logic                 device_rvalid_o;
  logic [DataWidth-1:0] device_rdata_o;

  modport master (
    output device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
    input  device_rvalid_o, device_rdata_o
  );

  modport slave (
    input  device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
    output device_rvalid_o, device_rdata_o
  );
endinterface

// File: rtl/vga_timing_counter.sv
// Pixel-tick divider and horizontal/vertical position counters.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int unsigned HT     = 800,
  parameter int unsigned VT     = 525,
  parameter int unsigned PixDiv = 2,
  parameter int unsigned W      = CntW
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_enable,
  output logic         o_tick,
  output logic [W-1:0] o_hc,
  output logic [W-1:0] o_vc,
  output logic         o_frame_start
);

  localparam int unsigned    DivW    = (PixDiv > 1) ? $clog2(PixDiv) : 1;
  localparam logic [DivW-1:0] DivLoad = DivW'(PixDiv - 1);
  localparam logic [W-1:0]    HLast   = W'(HT - 1);
  localparam logic [W-1:0]    VLast   = W'(VT - 1);

  logic [DivW-1:0] r_div;
  logic [W-1:0]    r_hc;
  logic [W-1:0]    r_vc;
  logic            w_tick;

  // Down-counter: the tick is the terminal count, so the first tick lands
  // on the first enabled cycle.
  assign w_tick = i_enable && (r_div == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_enable) begin
      r_div <= '0;
      r_hc  <= '0;
      r_vc  <= '0;
    end else begin
      r_div <= (r_div == '0) ? DivLoad : r_div - DivW'(1);
      if (w_tick) begin
        if (r_hc == HLast) begin
          r_hc <= '0;
          r_vc <= (r_vc == VLast) ? '0 : r_vc + W'(1);
        end else begin
          r_hc <= r_hc + W'(1);
        end
      end
    end
  end

  assign o_tick        = w_tick;
  assign o_hc          = r_hc;
  assign o_vc          = r_vc;
  assign o_frame_start = w_tick && (r_hc == HLast) && (r_vc == VLast);

endmodule

// File: rtl/vga_timing_ctrl.sv
// Bus-programmable VGA timing generator: syncs, background and one foreground box.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned CD        = 12,
  parameter int unsigned HD        = H_DISP,
  parameter int unsigned HF        = H_FP,
  parameter int unsigned HR        = H_SYNC,
  parameter int unsigned HB        = H_BP,
  parameter int unsigned VD        = V_DISP,
  parameter int unsigned VF        = V_FP,
  parameter int unsigned VR        = V_SYNC,
  parameter int unsigned VB        = V_BP,
  parameter int unsigned PixDiv    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  vga_timing_ctrl_if.slave   bus,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic [CD-1:0]      rgb_o
);

  localparam int unsigned    HT     = HD + HF + HR + HB;
  localparam int unsigned    VT     = VD + VF + VR + VB;
  localparam logic [CntW-1:0] HdC    = CntW'(HD);
  localparam logic [CntW-1:0] HsBeg  = CntW'(HD + HF);
  localparam logic [CntW-1:0] HsEnd  = CntW'(HD + HF + HR - 1);
  localparam logic [CntW-1:0] VdC    = CntW'(VD);
  localparam logic [CntW-1:0] VsBeg  = CntW'(VD + VF);
  localparam logic [CntW-1:0] VsEnd  = CntW'(VD + VF + VR - 1);

  logic [2:0]      r_ctrl;
  logic [CD-1:0]   r_bg_stg;
  logic [CD-1:0]   r_fg_stg;
  box_t            r_box_stg;
  logic [CD-1:0]   r_bg;
  logic [CD-1:0]   r_fg;
  box_t            r_box;
  logic [31:0]     r_frame_cnt;
  logic            r_rvalid;
  logic [31:0]     r_rdata;
  logic            r_hsync;
  logic            r_vsync;
  logic [CD-1:0]   r_rgb;

  logic            w_en;
  logic            w_tick;
  logic            w_frame_start;
  logic [CntW-1:0] w_hc;
  logic [CntW-1:0] w_vc;
  logic            w_hblank;
  logic            w_vblank;
  logic            w_hs_act;
  logic            w_vs_act;
  logic            w_in_box;
  reg_idx_e        w_idx;
  logic            w_wr;
  logic [31:0]     w_wdata;
  logic [31:0]     w_rd_val;
  logic [31:0]     w_merged;
  logic            w_unused;

  assign w_en = r_ctrl[0];

  vga_timing_counter #(
    .HT     (HT),
    .VT     (VT),
    .PixDiv (PixDiv),
    .W      (CntW)
  ) u_counter (
    .i_clk         (clk_i),
    .i_rst_n       (rst_ni),
    .i_enable      (w_en),
    .o_tick        (w_tick),
    .o_hc          (w_hc),
    .o_vc          (w_vc),
    .o_frame_start (w_frame_start)
  );

  assign w_hblank = (w_hc >= HdC);
  assign w_vblank = (w_vc >= VdC);
  assign w_hs_act = (w_hc >= HsBeg) && (w_hc <= HsEnd);
  assign w_vs_act = (w_vc >= VsBeg) && (w_vc <= VsEnd);
  assign w_in_box = ({1'b0, r_box.x0} <= w_hc) && (w_hc <= {1'b0, r_box.x1}) &&
                    ({1'b0, r_box.y0} <= w_vc) && (w_vc <= {1'b0, r_box.y1});

  assign w_idx   = reg_idx_e'(bus.device_addr_i[4:2]);
  assign w_wr    = bus.device_req_i && bus.device_we_i;
  assign w_wdata = bus.device_wdata_i[31:0];

  always_comb begin
    w_rd_val = '0;
    case (w_idx)
      REG_CTRL:      w_rd_val = {29'b0, r_ctrl};
      REG_BG:        w_rd_val = {{(32-CD){1'b0}}, r_bg_stg};
      REG_FG:        w_rd_val = {{(32-CD){1'b0}}, r_fg_stg};
      REG_BOX_START: w_rd_val = {5'b0, r_box_stg.y0, 5'b0, r_box_stg.x0};
      REG_BOX_END:   w_rd_val = {5'b0, r_box_stg.y1, 5'b0, r_box_stg.x1};
      REG_STATUS:    w_rd_val = {r_frame_cnt[15:0], 14'b0, w_hblank, w_vblank};
      REG_FRAME_CNT: w_rd_val = r_frame_cnt;
      default:       w_rd_val = '0;
    endcase
  end

  // Byte-enable merge uses the staging value as the old contents.
  assign w_merged = be_merge(w_rd_val, w_wdata, bus.device_be_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ctrl    <= '0;
      r_bg_stg  <= '0;
      r_fg_stg  <= '0;
      r_box_stg <= '0;
    end else if (w_wr) begin
      case (w_idx)
        REG_CTRL: r_ctrl   <= w_merged[2:0];
        REG_BG:   r_bg_stg <= w_merged[CD-1:0];
        REG_FG:   r_fg_stg <= w_merged[CD-1:0];
        REG_BOX_START: begin
          r_box_stg.x0 <= w_merged[10:0];
          r_box_stg.y0 <= w_merged[26:16];
        end
        REG_BOX_END: begin
          r_box_stg.x1 <= w_merged[10:0];
          r_box_stg.y1 <= w_merged[26:16];
        end
        default: ;
      endcase
    end
  end

  // Active copies sample staging before any same-cycle write lands.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_bg  <= '0;
      r_fg  <= '0;
      r_box <= '0;
    end else if (!w_en || w_frame_start) begin
      r_bg  <= r_bg_stg;
      r_fg  <= r_fg_stg;
      r_box <= r_box_stg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_frame_cnt <= '0;
    end else if (w_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= bus.device_req_i;
      r_rdata  <= (bus.device_req_i && !bus.device_we_i) ? w_rd_val : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= '0;
    end else begin
      r_hsync <= (w_en && w_hs_act) ~^ r_ctrl[1];
      r_vsync <= (w_en && w_vs_act) ~^ r_ctrl[2];
      if (w_en && !w_hblank && !w_vblank) begin
        r_rgb <= w_in_box ? r_fg : r_bg;
      end else begin
        r_rgb <= '0;
      end
    end
  end

  assign hsync_o             = r_hsync;
  assign vsync_o             = r_vsync;
  assign rgb_o               = r_rgb;
  assign bus.device_rvalid_o = r_rvalid;
  assign bus.device_rdata_o  = DataWidth'(r_rdata);

  assign w_unused = ^{w_tick, w_merged, bus.device_addr_i[AddrWidth-1:5],
                      bus.device_addr_i[1:0]};

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a 15x7 total, PixDiv=2 timing.
module tb_vga_timing_ctrl;

  logic        clk;
  logic        rst_n;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  int          errors;
  int          checks;

  vga_timing_ctrl_if #(.AddrWidth(32), .DataWidth(32)) bus_if ();

  vga_timing_ctrl #(
    .CD(12), .HD(8), .HF(2), .HR(3), .HB(2),
    .VD(4), .VF(1), .VR(1), .VB(1),
    .PixDiv(2), .AddrWidth(32), .DataWidth(32)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus_if),
    .hsync_o (hsync),
    .vsync_o (vsync),
    .rgb_o   (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                           output logic v, output logic [31:0] rd);
    @(negedge clk);
    bus_if.device_req_i   = 1'b1;
    bus_if.device_we_i    = 1'b1;
    bus_if.device_addr_i  = a;
    bus_if.device_wdata_i = d;
    bus_if.device_be_i    = b;
    @(negedge clk);
    bus_if.device_req_i   = 1'b0;
    bus_if.device_we_i    = 1'b0;
    v  = bus_if.device_rvalid_o;
    rd = bus_if.device_rdata_o;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic v, output logic [31:0] rd);
    @(negedge clk);
    bus_if.device_req_i  = 1'b1;
    bus_if.device_we_i   = 1'b0;
    bus_if.device_addr_i = a;
    bus_if.device_be_i   = 4'hF;
    @(negedge clk);
    bus_if.device_req_i  = 1'b0;
    v  = bus_if.device_rvalid_o;
    rd = bus_if.device_rdata_o;
  endtask

  // Leaves the bench on the first negedge where vsync_o shows lvl_then after lvl_first.
  task automatic wait_vsync(input logic lvl_first, input logic lvl_then, input string tag);
    int n;
    n = 0;
    while (vsync !== lvl_first && n < 1000) begin
      @(negedge clk);
      n++;
    end
    while (vsync !== lvl_then && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s: vsync edge not seen within %0d clks, vsync=%b", tag, n, vsync);
    end
  endtask

  task automatic test_reset();
    logic v;
    logic [31:0] d;
    checks += 5;
    if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", hsync); end
    if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vsync); end
    if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    if (bus_if.device_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL reset_rvalid: got %b want 0", bus_if.device_rvalid_o);
    end
    if (bus_if.device_rdata_o !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", bus_if.device_rdata_o);
    end
    bus_read(32'h18, v, d);
    checks += 3;
    if (v !== 1'b1) begin errors++; $display("FAIL idle_rvalid: got %b want 1", v); end
    if (d !== 32'h0) begin errors++; $display("FAIL idle_frame_cnt: got %h want 0", d); end
    @(negedge clk);
    if (bus_if.device_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL rvalid_one_cycle: got %b want 0", bus_if.device_rvalid_o);
    end
  endtask

  task automatic test_registers();
    logic v;
    logic [31:0] d;
    bus_write(32'h04, 32'h0000_0123, 4'hF, v, d);
    checks += 2;
    if (v !== 1'b1) begin errors++; $display("FAIL write_rvalid: got %b want 1", v); end
    if (d !== 32'h0) begin errors++; $display("FAIL write_rdata: got %h want 0", d); end
    bus_read(32'h04, v, d);
    checks++;
    if (d !== 32'h123) begin errors++; $display("FAIL bg_full: got %h want 123", d); end
    bus_write(32'h04, 32'h0000_0ABC, 4'b0001, v, d);
    bus_read(32'h04, v, d);
    checks++;
    if (d !== 32'h1BC) begin errors++; $display("FAIL bg_partial: got %h want 1bc", d); end
    bus_write(32'h0C, 32'hFFFF_FFFF, 4'hF, v, d);
    bus_read(32'h0C, v, d);
    checks++;
    if (d !== 32'h07FF_07FF) begin errors++; $display("FAIL box_unused_bits: got %h want 07ff07ff", d); end
    bus_write(32'h1C, 32'hFFFF_FFFF, 4'hF, v, d);
    bus_read(32'h1C, v, d);
    checks += 2;
    if (v !== 1'b1) begin errors++; $display("FAIL rsvd_rvalid: got %b want 1", v); end
    if (d !== 32'h0) begin errors++; $display("FAIL rsvd_read: got %h want 0", d); end
    bus_write(32'h14, 32'hFFFF_FFFF, 4'hF, v, d);
    bus_read(32'h14, v, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL status_ro: got %h want 0", d); end
  endtask

  task automatic test_back_to_back();
    logic v0, v1, v2, v3;
    logic [31:0] d0, d1, d2;
    @(negedge clk);
    bus_if.device_req_i   = 1'b1;
    bus_if.device_we_i    = 1'b1;
    bus_if.device_addr_i  = 32'h08;
    bus_if.device_wdata_i = 32'h0000_0F00;
    bus_if.device_be_i    = 4'hF;
    @(negedge clk);
    v0 = bus_if.device_rvalid_o; d0 = bus_if.device_rdata_o;
    bus_if.device_we_i   = 1'b0;
    bus_if.device_addr_i = 32'h08;
    @(negedge clk);
    v1 = bus_if.device_rvalid_o; d1 = bus_if.device_rdata_o;
    bus_if.device_addr_i = 32'h04;
    @(negedge clk);
    v2 = bus_if.device_rvalid_o; d2 = bus_if.device_rdata_o;
    bus_if.device_req_i = 1'b0;
    @(negedge clk);
    v3 = bus_if.device_rvalid_o;
    checks += 7;
    if (v0 !== 1'b1 || d0 !== 32'h0) begin errors++; $display("FAIL b2b_write: got v=%b d=%h want v=1 d=0", v0, d0); end
    if (v1 !== 1'b1) begin errors++; $display("FAIL b2b_rvalid1: got %b want 1", v1); end
    if (d1 !== 32'hF00) begin errors++; $display("FAIL b2b_read_fg: got %h want f00", d1); end
    if (v2 !== 1'b1) begin errors++; $display("FAIL b2b_rvalid2: got %b want 1", v2); end
    if (d2 !== 32'h1BC) begin errors++; $display("FAIL b2b_read_bg: got %h want 1bc", d2); end
    if (v3 !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", v3); end
    if (hsync !== 1'b1 || rgb !== 12'h0) begin
      errors++; $display("FAIL disabled_outputs: got hsync=%b rgb=%h want 1 000", hsync, rgb);
    end
  endtask

  task automatic test_frame_count();
    logic v;
    logic [31:0] d;
    bus_write(32'h04, 32'h0000_000F, 4'hF, v, d);
    bus_write(32'h08, 32'h0000_0F00, 4'hF, v, d);
    bus_write(32'h0C, 32'h0001_0002, 4'hF, v, d);
    bus_write(32'h10, 32'h0002_0004, 4'hF, v, d);
    bus_write(32'h00, 32'h0000_0001, 4'hF, v, d);
    repeat (630) @(negedge clk);
    bus_read(32'h18, v, d);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL frame_cnt_3: got %0d want 3", d); end
  endtask

  // Starts on the first sample of pixel (hc=0, vc=5); each pixel spans two samples.
  task automatic test_frame_scan(input logic hp, input logic vp, input logic [11:0] box_rgb,
                                 input string tag);
    int p, hc, vc;
    logic exp_hs, exp_vs;
    logic [11:0] exp_rgb;
    for (int k = 0; k < 210; k++) begin
      if (k > 0) @(negedge clk);
      p  = k / 2;
      hc = p % 15;
      vc = (5 + p / 15) % 7;
      exp_hs = (hc >= 10 && hc <= 12) ~^ hp;
      exp_vs = (vc == 5) ~^ vp;
      if (hc < 8 && vc < 4)
        exp_rgb = (hc >= 2 && hc <= 4 && vc >= 1 && vc <= 2) ? box_rgb : 12'h00F;
      else
        exp_rgb = 12'h000;
      checks += 3;
      if (hsync !== exp_hs) begin
        errors++; $display("FAIL %s_hsync hc=%0d vc=%0d: got %b want %b", tag, hc, vc, hsync, exp_hs);
      end
      if (vsync !== exp_vs) begin
        errors++; $display("FAIL %s_vsync hc=%0d vc=%0d: got %b want %b", tag, hc, vc, vsync, exp_vs);
      end
      if (rgb !== exp_rgb) begin
        errors++; $display("FAIL %s_rgb hc=%0d vc=%0d: got %h want %h", tag, hc, vc, rgb, exp_rgb);
      end
    end
  endtask

  task automatic test_status_vblank();
    logic v;
    logic [31:0] d;
    bus_read(32'h14, v, d);
    checks++;
    if (d !== 32'h0004_0001) begin errors++; $display("FAIL status_vblank: got %h want 00040001", d); end
  endtask

  task automatic test_shadow_midframe();
    logic v;
    logic [31:0] d;
    wait_vsync(1'b1, 1'b0, "align_mid");
    repeat (59) @(negedge clk);
    bus_write(32'h08, 32'h0000_00F0, 4'hF, v, d);
    repeat (35) @(negedge clk);
    checks++;
    if (rgb !== 12'hF00) begin errors++; $display("FAIL shadow_mid_same_frame: got %h want f00", rgb); end
    repeat (210) @(negedge clk);
    checks++;
    if (rgb !== 12'h0F0) begin errors++; $display("FAIL shadow_mid_next_frame: got %h want 0f0", rgb); end
  endtask

  task automatic test_shadow_at_frame_start();
    logic v;
    logic [31:0] d;
    wait_vsync(1'b1, 1'b0, "align_fs");
    repeat (57) @(negedge clk);
    bus_write(32'h08, 32'h0000_0FF0, 4'hF, v, d);
    repeat (37) @(negedge clk);
    checks++;
    if (rgb !== 12'h0F0) begin errors++; $display("FAIL shadow_fs_first_frame: got %h want 0f0", rgb); end
    repeat (210) @(negedge clk);
    checks++;
    if (rgb !== 12'hFF0) begin errors++; $display("FAIL shadow_fs_second_frame: got %h want ff0", rgb); end
  endtask

  task automatic test_polarity_empty_box();
    logic v;
    logic [31:0] d;
    bus_write(32'h0C, 32'h0001_0005, 4'hF, v, d);
    bus_write(32'h00, 32'h0000_0007, 4'hF, v, d);
    repeat (220) @(negedge clk);
    wait_vsync(1'b0, 1'b1, "align_pol");
    test_frame_scan(1'b1, 1'b1, 12'h00F, "pol");
  endtask

  task automatic test_reset_midframe();
    logic v;
    logic [31:0] d;
    wait_vsync(1'b0, 1'b1, "align_rst");
    repeat (60) @(negedge clk);
    checks++;
    if (rgb !== 12'h00F) begin errors++; $display("FAIL pre_reset_rgb: got %h want 00f", rgb); end
    rst_n = 1'b0;
    bus_if.device_req_i  = 1'b1;
    bus_if.device_we_i   = 1'b0;
    bus_if.device_addr_i = 32'h00;
    @(negedge clk);
    checks += 5;
    if (hsync !== 1'b1) begin errors++; $display("FAIL midrst_hsync: got %b want 1", hsync); end
    if (vsync !== 1'b1) begin errors++; $display("FAIL midrst_vsync: got %b want 1", vsync); end
    if (rgb !== 12'h000) begin errors++; $display("FAIL midrst_rgb: got %h want 000", rgb); end
    if (bus_if.device_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL midrst_rvalid: got %b want 0", bus_if.device_rvalid_o);
    end
    if (bus_if.device_rdata_o !== 32'h0) begin
      errors++; $display("FAIL midrst_rdata: got %h want 0", bus_if.device_rdata_o);
    end
    bus_if.device_req_i = 1'b0;
    rst_n = 1'b1;
    bus_read(32'h00, v, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midrst_ctrl: got %h want 0", d); end
    bus_read(32'h18, v, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midrst_frame_cnt: got %h want 0", d); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus_if.device_req_i   = 1'b0;
    bus_if.device_we_i    = 1'b0;
    bus_if.device_addr_i  = '0;
    bus_if.device_be_i    = '0;
    bus_if.device_wdata_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_registers();
    test_back_to_back();
    test_frame_count();
    wait_vsync(1'b1, 1'b0, "align_scan");
    test_frame_scan(1'b0, 1'b0, 12'hF00, "scan");
    test_status_vblank();
    test_shadow_midframe();
    test_shadow_at_frame_start();
    test_polarity_empty_box();
    test_reset_midframe();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
